conv_layer_mem: RTL and testbench
=================================

Name: conv_layer_mem

Overview:
- Synthesizable responder for the CONV layer-result memory interface (cwr/crd/csel/caddr_wr/caddr_rd/cdata_wr/cdata_rd).
- Holds five result banks selected by csel: layer-0 kernel 0/1, layer-1 kernel 0/1, layer-2 flatten.
- Replaces the behavioural result memory, so CONV and its memories can be synthesized and measured together.
- Also tracks per-layer write completion and flags protocol violations.

Parameters:
- DW, 20, data width of every bank word.
- AW, 12, address width on caddr_wr/caddr_rd.
- L0_DEPTH, 4096, words in each layer-0 bank (csel 001, 010).
- L1_DEPTH, 1024, words in each layer-1 bank (csel 011, 100).
- L2_DEPTH, 2048, words in the layer-2 bank (csel 101).

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  synchronous, active-high.
- cwr  in  1  write strobe.
- caddr_wr  in  AW  write address.
- cdata_wr  in  DW  write data.
- crd  in  1  read strobe.
- caddr_rd  in  AW  read address.
- csel  in  3  bank select, shared by read and write.
- cdata_rd  out  DW  registered read data.
- l0_done  out  1  both layer-0 banks have accepted at least L0_DEPTH writes.
- l1_done  out  1  same condition for the two layer-1 banks, with L1_DEPTH.
- l2_done  out  1  layer-2 bank has accepted at least L2_DEPTH writes.
- sel_err  out  1  sticky: strobe seen with csel in {000, 110, 111}.
- addr_err  out  1  sticky: strobe address is at or above the selected bank's depth.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - cdata_rd = 0; all done flags and error flags = 0; all write counters = 0.
  - Bank contents are not cleared.
  - Reset asserted mid-operation: a write at that edge is dropped; the read register clears.
- Write:
  - At a rising edge with cwr=1, a valid csel and an in-range caddr_wr, the word bank[csel][caddr_wr] takes cdata_wr.
  - That bank's counter increments, saturating at its depth.
- Read:
  - At a rising edge with crd=1, a valid csel and an in-range caddr_rd, cdata_rd takes bank[csel][caddr_rd].
  - Data is valid from that edge; latency is 1 cycle.
  - cdata_rd holds its value while crd=0 and on rejected reads.
- cwr and crd in the same cycle:
  - Both are serviced, using the same csel.
  - If the bank and address match, the read returns the old word (read-first).
- Invalid csel (000, 110, 111) with cwr or crd: no bank access, sel_err set. Counters unchanged.
- Out-of-range address:
  - Applies when addr ≥ bank depth; only the layer-1 and layer-2 banks can hit this at AW=12.
  - Access is ignored and addr_err is set.
  - Each strobe is checked independently.
- Error flags stay set until reset.
- Done flags:
  - Combinational compare of saturated counter ≥ depth, registered one cycle.
  - A flag rises on the edge after the completing write.
  - Rewrites count toward the total; no per-address tracking.
- Counter width: ceil(log2(depth+1)) per bank.

Decomposition:
- Package conv_mem_pkg holds:
  - csel codes: CSEL_L0K0=3'b001, CSEL_L0K1=3'b010, CSEL_L1K0=3'b011, CSEL_L1K1=3'b100, CSEL_L2=3'b101.
  - DW/AW defaults and the three depth constants.
  - A function csel_valid.
- One sub-module, conv_bank_ram, parameterised by DEPTH/DW:
  - One write port and one registered read port, read-first.
  - Instanced five times.
  - The top level does decode, counters, flags and the output mux.

Test Plan:
- Reset, then write csel=001 addr=0x005 data=0xABCDE; next cycle read the same location → cdata_rd=0xABCDE one edge after crd. Flags stay 0.
- Same-cycle cwr and crd on csel=011 addr=0x010: old word 0x00011, new word 0x00022 → cdata_rd=0x00011 that cycle; a following read returns 0x00022.
- Write all 4096 addresses of banks 001 and 010 → l0_done=1 exactly one edge after the 8192nd write; l1_done=0 and l2_done=0.
- Write csel=100 addr=0x400 → no write, addr_err=1. Read csel=101 addr=0x7FF → accepted, no error.
- Strobe cwr with csel=110 → sel_err=1, counters unchanged; reset clears sel_err to 0 and cdata_rd to 0.
- Assert reset mid-stream during layer-1 writes → counters cleared to 0; a write coinciding with reset does not appear in memory.

Source files
------------

// File: rtl/conv_mem_pkg.sv
// conv_mem_pkg: shared bank select codes, default sizes and select decode for the CONV result memory
package conv_mem_pkg;
  localparam int CONV_DW = 20;
  localparam int CONV_AW = 12;
  localparam int CONV_L0_DEPTH = 4096;
  localparam int CONV_L1_DEPTH = 1024;
  localparam int CONV_L2_DEPTH = 2048;
  localparam int NB = 5;
  localparam logic [2:0] CSEL_L0K0 = 3'b001;
  localparam logic [2:0] CSEL_L0K1 = 3'b010;
  localparam logic [2:0] CSEL_L1K0 = 3'b011;
  localparam logic [2:0] CSEL_L1K1 = 3'b100;
  localparam logic [2:0] CSEL_L2 = 3'b101;
  function automatic logic csel_valid(input logic [2:0] s);
    return s inside {CSEL_L0K0, CSEL_L0K1, CSEL_L1K0, CSEL_L1K1, CSEL_L2};
  endfunction
endpackage

// File: rtl/conv_bank_ram.sv
// conv_bank_ram: single-port-write, registered-read, read-first result bank
module conv_bank_ram #(
  parameter int DEPTH = 1024,
  parameter int DW = 20,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  // write and read at the same edge; the read sees the pre-write word
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/conv_layer_mem.sv
// conv_layer_mem: five-bank CONV result memory with write completion tracking and protocol error flags
module conv_layer_mem
  import conv_mem_pkg::*;
#(
  parameter int DW = CONV_DW,
  parameter int AW = CONV_AW,
  parameter int L0_DEPTH = CONV_L0_DEPTH,
  parameter int L1_DEPTH = CONV_L1_DEPTH,
  parameter int L2_DEPTH = CONV_L2_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  input  logic [2:0]    csel,
  output logic [DW-1:0] cdata_rd,
  output logic          l0_done,
  output logic          l1_done,
  output logic          l2_done,
  output logic          sel_err,
  output logic          addr_err
);
  function automatic logic in_rng(input logic [2:0] s, input logic [AW-1:0] a);
    return int'(a) < ((s == CSEL_L0K0 || s == CSEL_L0K1) ? L0_DEPTH :
                      (s == CSEL_L1K0 || s == CSEL_L1K1) ? L1_DEPTH : L2_DEPTH);
  endfunction
  logic          sv, wr_ok, rd_ok;
  logic [2:0]    rd_sel;
  logic [NB-1:0] full;
  logic [DW-1:0] rdata [NB];
  assign sv = csel_valid(csel);
  assign wr_ok = !reset && cwr && sv && in_rng(csel, caddr_wr);
  assign rd_ok = !reset && crd && sv && in_rng(csel, caddr_rd);
  for (genvar b = 0; b < NB; b++) begin : g_bank
    localparam int D = b < 2 ? L0_DEPTH : b < 4 ? L1_DEPTH : L2_DEPTH;
    localparam int CW = $clog2(D + 1);
    logic [CW-1:0] cnt;
    logic          we, re;
    assign we = wr_ok && csel == 3'(b + 1);
    assign re = rd_ok && csel == 3'(b + 1);
    assign full[b] = cnt == CW'(D);
    // saturating count of accepted writes to this bank
    always_ff @(posedge clk)
      if (reset) cnt <= '0;
      else if (we && !full[b]) cnt <= cnt + 1'b1;
    conv_bank_ram #(.DEPTH(D), .DW(DW)) u_ram (
      .clk(clk),
      .we(we),
      .waddr(caddr_wr[$clog2(D)-1:0]),
      .wdata(cdata_wr),
      .re(re),
      .raddr(caddr_rd[$clog2(D)-1:0]),
      .rdata(rdata[b])
    );
  end
  // sticky error flags, registered done flags and the bank that owns cdata_rd (000 = cleared)
  always_ff @(posedge clk)
    if (reset) begin
      sel_err <= 1'b0;
      addr_err <= 1'b0;
      l0_done <= 1'b0;
      l1_done <= 1'b0;
      l2_done <= 1'b0;
      rd_sel <= 3'b000;
    end else begin
      sel_err <= sel_err | ((cwr | crd) & !sv);
      addr_err <= addr_err | (sv & ((cwr & !in_rng(csel, caddr_wr)) | (crd & !in_rng(csel, caddr_rd))));
      l0_done <= full[0] & full[1];
      l1_done <= full[2] & full[3];
      l2_done <= full[4];
      if (rd_ok) rd_sel <= csel;
    end
  // each bank holds its last read word, so selecting the last-read bank gives hold-on-reject
  always_comb cdata_rd = csel_valid(rd_sel) ? rdata[rd_sel - 3'd1] : '0;
endmodule

// File: tb/tb_conv_layer_mem.sv
// tb_conv_layer_mem: directed scoreboard bench for conv_layer_mem
module tb_conv_layer_mem;
  logic        clk = 0, reset = 1, cwr = 0, crd = 0;
  logic [11:0] caddr_wr = 0, caddr_rd = 0;
  logic [19:0] cdata_wr = 0;
  logic [2:0]  csel = 0;
  logic [19:0] cdata_rd;
  logic        l0_done, l1_done, l2_done, sel_err, addr_err;
  int          checks = 0, errors = 0;
  logic [19:0] exp_q [$];
  logic [19:0] mdl [8][4096];
  logic [19:0] last = 0;

  conv_layer_mem dut (
    .clk(clk), .reset(reset), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .csel(csel), .cdata_rd(cdata_rd),
    .l0_done(l0_done), .l1_done(l1_done), .l2_done(l2_done),
    .sel_err(sel_err), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  function automatic int dep(input logic [2:0] s);
    return (s == 1 || s == 2) ? 4096 : (s == 3 || s == 4) ? 1024 : (s == 5) ? 2048 : 0;
  endfunction

  task automatic chk(input string name, input logic [19:0] got, input logic [19:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // one bus cycle starting at a negedge; expected read data is queued before the model updates
  task automatic cyc(input logic w, input logic r, input logic [2:0] s,
                     input logic [11:0] aw, input logic [11:0] ar, input logic [19:0] d);
    cwr = w; crd = r; csel = s; caddr_wr = aw; caddr_rd = ar; cdata_wr = d;
    if (r) begin
      if (int'(ar) < dep(s)) last = mdl[s][ar];
      exp_q.push_back(last);
    end
    if (w && int'(aw) < dep(s)) mdl[s][aw] = d;
    @(negedge clk);
    cwr = 0; crd = 0;
  endtask

  // monitor: every read strobe seen at an edge is compared 1 time unit later
  always @(posedge clk) begin
    logic c;
    c = crd && !reset;
    #1;
    if (c) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got %h", cdata_rd);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if (cdata_rd !== e) begin
          errors++;
          $display("FAIL rd_data got %h want %h", cdata_rd, e);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_rd", cdata_rd, 0);
    chk("rst_flags", {15'b0, l0_done, l1_done, l2_done, sel_err, addr_err}, 0);
    cyc(1, 0, 1, 12'h005, 0, 20'hABCDE);
    cyc(0, 1, 1, 0, 12'h005, 0);
    chk("t1_flags", {15'b0, l0_done, l1_done, l2_done, sel_err, addr_err}, 0);
    cyc(1, 0, 3, 12'h010, 0, 20'h00011);
    cyc(1, 1, 3, 12'h010, 12'h010, 20'h00022);
    cyc(0, 1, 3, 0, 12'h010, 0);
    @(negedge clk);
    chk("hold", cdata_rd, 20'h00022);
    for (int a = 0; a < 4096; a++) cyc(1, 0, 1, 12'(a), 0, 20'(a) ^ 20'h5A5A5);
    for (int a = 0; a < 4095; a++) cyc(1, 0, 2, 12'(a), 0, 20'(a) ^ 20'h0F0F0);
    chk("l0_early", {19'b0, l0_done}, 0);
    cyc(1, 0, 2, 12'hFFF, 0, 20'h13579);
    chk("l0_same_edge", {19'b0, l0_done}, 0);
    @(negedge clk);
    chk("l0_done", {19'b0, l0_done}, 1);
    chk("l1l2_idle", {18'b0, l1_done, l2_done}, 0);
    cyc(0, 1, 2, 0, 12'h123, 0);
    cyc(0, 1, 2, 0, 12'hFFF, 0);
    cyc(1, 0, 5, 12'h7FF, 0, 20'h77777);
    cyc(0, 1, 5, 0, 12'h7FF, 0);
    chk("l2_no_err", {18'b0, sel_err, addr_err}, 0);
    cyc(1, 0, 4, 12'h400, 0, 20'hBAD00);
    chk("addr_err", {19'b0, addr_err}, 1);
    cyc(0, 1, 3, 0, 12'h400, 0);
    chk("sel_clear", {19'b0, sel_err}, 0);
    cyc(1, 0, 6, 12'h001, 0, 20'hBAD01);
    chk("sel_err", {19'b0, sel_err}, 1);
    cyc(0, 1, 7, 0, 12'h001, 0);
    chk("l0_kept", {19'b0, l0_done}, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    last = 0;
    chk("rst2_rd", cdata_rd, 0);
    chk("rst2_flags", {15'b0, l0_done, l1_done, l2_done, sel_err, addr_err}, 0);
    for (int a = 0; a < 10; a++) cyc(1, 0, 3, 12'(a), 0, 20'(a) + 20'h300);
    cyc(1, 0, 3, 12'h020, 0, 20'h12345);
    reset = 1; cwr = 1; csel = 3; caddr_wr = 12'h020; cdata_wr = 20'h0DEAD;
    @(negedge clk);
    reset = 0; cwr = 0;
    cyc(0, 1, 3, 0, 12'h020, 0);
    for (int a = 0; a < 1023; a++) cyc(1, 0, 3, 12'(a), 0, 20'(a) ^ 20'hC3C3C);
    for (int a = 0; a < 1024; a++) cyc(1, 0, 4, 12'(a), 0, 20'(a) ^ 20'h3C3C3);
    @(negedge clk);
    chk("l1_cleared_cnt", {19'b0, l1_done}, 0);
    cyc(1, 0, 3, 12'h3FF, 0, 20'h24680);
    @(negedge clk);
    chk("l1_done", {19'b0, l1_done}, 1);
    chk("l0l2_idle", {18'b0, l0_done, l2_done}, 0);
    cyc(0, 1, 4, 0, 12'h2A5, 0);
    cyc(0, 1, 3, 0, 12'h3FF, 0);
    @(negedge clk);
    chk("queue_drained", 20'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
